keypad_scan: RTL and testbench
==============================

Name: keypad_scan

Overview:
- Input-side counterpart to the 7-segment scan display: scans a 4x4 matrix keypad (Pmod KYPD style) by driving one active-low column at a time.
- Reads the active-low rows, debounces, and emits a one-cycle key event with a 4-bit hex code.
- Maintains a two-digit BCD entry register (digit1:digit0) that feeds the display and counter path directly.

Parameters:
- SCAN_TICKS, 100000, clk cycles per column period (1 ms at 100 MHz); must be >= 4.
- DEBOUNCE_SCANS, 4, consecutive matching samples needed to accept a press or a release; must be >= 1.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- ROW  input  4  keypad rows, active-low, externally pulled up, asynchronous to clk
- COL  output  4  keypad column drive, active-low, exactly one bit low at all times
- key_code  output  4  hex code of the last accepted key
- key_valid  output  1  one-cycle pulse per accepted press
- key_held  output  1  high while an accepted key remains pressed
- digit0  output  4  BCD ones digit (most recent decimal key)
- digit1  output  4  BCD tens digit

Behaviour:
- Reset (async assert, sync release):
  - COL=4'b1110 (column 0), key_code=0, key_valid=0, key_held=0, digit0=digit1=0.
  - State SCAN, timer=0, debounce count=0.
- ROW passes through a 2-FF synchronizer; all logic uses the synchronized rows (rs).
- Timer counts 0..SCAN_TICKS-1 and wraps. The cycle with timer==SCAN_TICKS-1 is the sample tick; rs is evaluated only there (column has settled for the full period).
- Key map, [row][col]:
  - row0 = 1 2 3 A
  - row1 = 4 5 6 B
  - row2 = 7 8 9 C
  - row3 = 0 F E D
- Multiple low rows in one sample: the lowest row index wins. Keys in other columns are ignored while the column is frozen.
- FSM states: SCAN, DEBOUNCE, HELD, RELEASE.
- SCAN:
  - At a sample tick with rs==4'hF: advance the column (0->1->2->3->0) in the next cycle.
  - At a sample tick with any row low: latch candidate row, count=1, freeze the column, go to DEBOUNCE. If DEBOUNCE_SCANS==1, go straight to the accept action instead.
- DEBOUNCE, at each sample tick:
  - Candidate row low: count+1.
  - Candidate row high: count=0, return to SCAN and advance the column.
  - When count reaches DEBOUNCE_SCANS: accept.
- Accept (all registered, in the cycle after the confirming tick):
  - key_valid=1 for exactly one cycle.
  - key_code=map[row][col].
  - key_held=1.
  - Go to HELD.
- Digit update, in the same cycle as key_valid:
  - Code 0..9: digit1<=digit0, digit0<=code.
  - Code C: digit0=digit1=0.
  - A, B, D, E, F: digits unchanged.
- HELD:
  - Column stays frozen; no auto-repeat.
  - At a sample tick with candidate row high: count=1, go to RELEASE (or straight to release-accept if DEBOUNCE_SCANS==1).
- RELEASE, at each sample tick:
  - Candidate row high: count+1.
  - Candidate row low: count=0, back to HELD.
  - When count reaches DEBOUNCE_SCANS: key_held=0, advance the column, go to SCAN.
- key_code holds its value until the next accept.
- Reset asserted mid-press forces the reset values immediately. After release of reset, a still-pressed key is re-detected and re-accepted normally.
- Latency, stable press to key_valid: up to 4*SCAN_TICKS (find column) + (DEBOUNCE_SCANS-1)*SCAN_TICKS + 3 cycles (sync + register).
- Widths:
  - Timer: $clog2(SCAN_TICKS) bits.
  - Count: $clog2(DEBOUNCE_SCANS+1) bits, saturating.
  - COL is a registered one-cold rotate, never all-high or multi-low.

Decomposition:
- Package keypad_pkg: FSM state encoding; 16-entry key map constant indexed {row,col}; code constants KEY_CLEAR=4'hC and DEC_MAX=4'd9.
- One sub-module, row_sync: 4-bit 2-FF synchronizer with async active-low reset to 4'hF.
- Timer, FSM, and digit register stay in keypad_scan.

Test Plan (bench uses SCAN_TICKS=4, DEBOUNCE_SCANS=3; keypad model pulls ROW[r] low only while COL[c] is low and key (r,c) is pressed):
- Reset, no keys -> COL cycles 1110,1101,1011,0111 every 4 clks; key_valid never asserts; digits 0/0.
- Press key "7" (row2,col0) and hold -> exactly one key_valid pulse; key_code=4'h7; key_held=1; digit0=7, digit1=0; no second pulse while held.
- Release, then press "4" -> digit1=7, digit0=4; key_held drops 3 sample ticks after release.
- Press "C" (row2,col3) -> key_code=4'hC; digit0=digit1=0. Then press "B" -> key_code=4'hB; digits stay 0/0.
- Bounce: ROW[1] low for 2 sample ticks, then high (col2 active) -> no key_valid; FSM returns to SCAN and the column advances to col3.
- Hold "5" and assert rst_n=0 mid-HELD -> all outputs at reset values at once; after release "5" is re-accepted with one key_valid, digit0=5.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 matrix keypad scanner:
// FSM encoding, the {row,col} key map and the code helpers.
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2,
    ST_RELEASE  = 2'd3
  } kp_state_e;

  localparam logic [3:0] KEY_CLEAR = 4'hC;
  localparam logic [3:0] DEC_MAX   = 4'd9;

  // Nibble n holds the code for {row,col} == n; row3 reads 0 F E D.
  localparam logic [63:0] KEY_MAP = 64'hDEF0_C987_B654_A321;

  function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
    logic [5:0] base;
    base = {row, col, 2'b00};
    return KEY_MAP[base +: 4];
  endfunction

  // Lowest-indexed low row wins when several rows are pulled down together.
  function automatic logic [1:0] first_low_row(input logic [3:0] rows);
    logic [1:0] idx;
    casez (rows)
      4'b???0: idx = 2'd0;
      4'b??01: idx = 2'd1;
      4'b?011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  function automatic logic is_decimal(input logic [3:0] code);
    return (code <= DEC_MAX);
  endfunction

endpackage

// File: rtl/keypad_scan_row_sync.sv
// Two-flop synchronizer for the asynchronous, active-low keypad rows.
// Resets to all-high so an idle keypad is seen during reset release.
module row_sync (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_async,
  output logic [3:0] row_sync_r
);

  logic [3:0] meta_r;

  // Two-stage capture of the raw row lines.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r     <= 4'hF;
      row_sync_r <= 4'hF;
    end else begin
      meta_r     <= row_async;
      row_sync_r <= meta_r;
    end
  end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad scanner: rotates one low column, debounces press and release
// on the frozen column, and keeps a two-digit BCD entry register.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_TICKS     = 100000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] ROW,
  output logic [3:0] COL,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic [3:0] digit0,
  output logic [3:0] digit1
);

  localparam int TW = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_TICKS - 1);
  localparam logic [CW-1:0] CNT_TGT   = CW'(DEBOUNCE_SCANS);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO  = CW'(0);

  logic [3:0]    rs_s;
  logic [TW-1:0] timer_r;
  logic          tick_s;
  kp_state_e     state_r;
  kp_state_e     state_s;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_s;
  logic [CW-1:0] cnt_inc_s;
  logic [1:0]    col_idx_r;
  logic [1:0]    cand_row_r;
  logic [1:0]    cand_row_s;
  logic          cand_low_s;
  logic          advance_s;
  logic          accept_s;
  logic          release_s;
  logic [3:0]    code_s;

  row_sync u_row_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .row_async  (ROW),
    .row_sync_r (rs_s)
  );

  assign tick_s     = (timer_r == TICK_LAST);
  assign cand_low_s = ~rs_s[cand_row_r];
  assign cnt_inc_s  = (cnt_r == CNT_TGT) ? cnt_r : (cnt_r + CNT_ONE);
  // In the DEBOUNCE_SCANS==1 case the row is taken straight from the sample.
  assign code_s     = key_lookup(cand_row_s, col_idx_r);

  // Column period timer; the last count is the sample tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_r <= '0;
    end else if (tick_s) begin
      timer_r <= '0;
    end else begin
      timer_r <= timer_r + TW'(1);
    end
  end

  // Next-state and event decode, evaluated only on sample ticks.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    cand_row_s = cand_row_r;
    advance_s  = 1'b0;
    accept_s   = 1'b0;
    release_s  = 1'b0;
    if (tick_s) begin
      case (state_r)
        ST_SCAN: begin
          if (rs_s == 4'hF) begin
            advance_s = 1'b1;
          end else begin
            cand_row_s = first_low_row(rs_s);
            cnt_s      = CNT_ONE;
            if (DEBOUNCE_SCANS == 1) begin
              accept_s = 1'b1;
              state_s  = ST_HELD;
            end else begin
              state_s  = ST_DEBOUNCE;
            end
          end
        end
        ST_DEBOUNCE: begin
          if (cand_low_s) begin
            cnt_s = cnt_inc_s;
            if (cnt_inc_s == CNT_TGT) begin
              accept_s = 1'b1;
              state_s  = ST_HELD;
            end else begin
              state_s  = ST_DEBOUNCE;
            end
          end else begin
            cnt_s     = CNT_ZERO;
            advance_s = 1'b1;
            state_s   = ST_SCAN;
          end
        end
        ST_HELD: begin
          if (cand_low_s) begin
            state_s = ST_HELD;
          end else begin
            cnt_s = CNT_ONE;
            if (DEBOUNCE_SCANS == 1) begin
              release_s = 1'b1;
              advance_s = 1'b1;
              state_s   = ST_SCAN;
            end else begin
              state_s   = ST_RELEASE;
            end
          end
        end
        ST_RELEASE: begin
          if (!cand_low_s) begin
            cnt_s = cnt_inc_s;
            if (cnt_inc_s == CNT_TGT) begin
              release_s = 1'b1;
              advance_s = 1'b1;
              state_s   = ST_SCAN;
            end else begin
              state_s   = ST_RELEASE;
            end
          end else begin
            cnt_s   = CNT_ZERO;
            state_s = ST_HELD;
          end
        end
        default: begin
          cnt_s   = CNT_ZERO;
          state_s = ST_SCAN;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // FSM state, debounce count and candidate row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_SCAN;
      cnt_r      <= '0;
      cand_row_r <= 2'd0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      cand_row_r <= cand_row_s;
    end
  end

  // One-cold column rotate, frozen except when the FSM advances it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      COL       <= 4'b1110;
      col_idx_r <= 2'd0;
    end else if (advance_s) begin
      COL       <= {COL[2:0], COL[3]};
      col_idx_r <= col_idx_r + 2'd1;
    end else begin
      COL       <= COL;
      col_idx_r <= col_idx_r;
    end
  end

  // Key event outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_valid <= 1'b0;
      key_code  <= 4'h0;
      key_held  <= 1'b0;
    end else begin
      key_valid <= accept_s;
      if (accept_s) begin
        key_code <= code_s;
        key_held <= 1'b1;
      end else if (release_s) begin
        key_held <= 1'b0;
      end else begin
        key_held <= key_held;
      end
    end
  end

  // BCD entry register: decimal keys shift in, C clears, letters are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit0 <= 4'h0;
      digit1 <= 4'h0;
    end else if (accept_s) begin
      if (is_decimal(code_s)) begin
        digit1 <= digit0;
        digit0 <= code_s;
      end else if (code_s == KEY_CLEAR) begin
        digit1 <= 4'h0;
        digit0 <= 4'h0;
      end else begin
        digit1 <= digit1;
        digit0 <= digit0;
      end
    end else begin
      digit1 <= digit1;
      digit0 <= digit0;
    end
  end

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with a column-gated keypad model.
module tb_keypad_scan;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] ROW;
  logic [3:0] COL;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;
  logic [3:0] digit0;
  logic [3:0] digit1;

  logic       pressed;
  logic [1:0] kr;
  logic [1:0] kc;

  int total = 0;
  int bad   = 0;
  int vcnt  = 0;

  always #5 clk = ~clk;

  // Keypad model: the pressed key pulls its row low only while its column is driven.
  always_comb begin
    ROW = 4'hF;
    if (pressed && (COL[kc] == 1'b0)) ROW[kr] = 1'b0;
  end

  always @(negedge clk) if (key_valid) vcnt <= vcnt + 1;

  keypad_scan #(.SCAN_TICKS(4), .DEBOUNCE_SCANS(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ROW       (ROW),
    .COL       (COL),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held),
    .digit0    (digit0),
    .digit1    (digit1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_valid(input int limit, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      if (key_valid) seen = 1'b1;
    end
  endtask

  task automatic wait_held_low(input int limit, output int cyc);
    cyc = -1;
    for (int i = 0; i < limit && cyc < 0; i++) begin
      @(negedge clk);
      if (!key_held) cyc = i + 1;
    end
  endtask

  task automatic press_and_release(input logic [1:0] r, input logic [1:0] c,
                                   input logic [3:0] exp_code, input logic [3:0] exp_d1,
                                   input logic [3:0] exp_d0);
    bit seen;
    int cyc;
    kr = r; kc = c; pressed = 1'b1;
    wait_valid(100, seen);
    chk("press_seen", 32'(seen), 32'd1);
    chk("press_code", 32'(key_code), 32'(exp_code));
    chk("press_d1", 32'(digit1), 32'(exp_d1));
    chk("press_d0", 32'(digit0), 32'(exp_d0));
    pressed = 1'b0;
    wait_held_low(60, cyc);
    chk("release_done", 32'(cyc > 0), 32'd1);
  endtask

  initial begin
    bit         seen;
    int         cyc;
    int         base;
    logic [3:0] exp_col;

    rst_n = 1'b0; pressed = 1'b0; kr = 2'd0; kc = 2'd0;
    repeat (3) @(negedge clk);
    chk("rst_col", 32'(COL), 32'h0000000E);
    chk("rst_code", 32'(key_code), 32'd0);
    chk("rst_valid", 32'(key_valid), 32'd0);
    chk("rst_held", 32'(key_held), 32'd0);
    chk("rst_d0", 32'(digit0), 32'd0);
    chk("rst_d1", 32'(digit1), 32'd0);

    // Idle scan: column changes on every fourth edge after reset release.
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    exp_col = 4'b1110;
    for (int i = 0; i < 5; i++) begin
      chk("idle_col", 32'(COL), 32'(exp_col));
      exp_col = {exp_col[2:0], exp_col[3]};
      repeat (4) @(negedge clk);
    end
    chk("idle_novalid", 32'(vcnt), 32'd0);
    chk("idle_d0", 32'(digit0), 32'd0);

    // Key 7 held: one pulse only.
    base = vcnt;
    kr = 2'd2; kc = 2'd0; pressed = 1'b1;
    wait_valid(100, seen);
    chk("k7_seen", 32'(seen), 32'd1);
    chk("k7_code", 32'(key_code), 32'h7);
    chk("k7_held", 32'(key_held), 32'd1);
    chk("k7_d0", 32'(digit0), 32'd7);
    chk("k7_d1", 32'(digit1), 32'd0);
    repeat (40) @(negedge clk);
    chk("k7_single", 32'(vcnt - base), 32'd1);
    chk("k7_still_held", 32'(key_held), 32'd1);

    // Release latency: first high tick plus two more confirming ticks.
    pressed = 1'b0;
    wait_held_low(60, cyc);
    chk("k7_rel_lat", 32'(cyc >= 11 && cyc <= 14), 32'd1);

    press_and_release(2'd1, 2'd0, 4'h4, 4'd7, 4'd4);
    press_and_release(2'd2, 2'd3, 4'hC, 4'd0, 4'd0);
    press_and_release(2'd1, 2'd3, 4'hB, 4'd0, 4'd0);

    // Bounce on row1/col2: two low samples then high.
    base = vcnt;
    kr = 2'd1; kc = 2'd2; pressed = 1'b1;
    cyc = -1;
    for (int i = 0; i < 100 && cyc < 0; i++) begin
      @(negedge clk);
      if (COL == 4'b1011) cyc = i;
    end
    chk("bnc_col2", 32'(cyc >= 0), 32'd1);
    repeat (8) @(negedge clk);
    chk("bnc_frozen", 32'(COL), 32'h0000000B);
    pressed = 1'b0;
    cyc = -1;
    for (int i = 0; i < 40 && cyc < 0; i++) begin
      @(negedge clk);
      if (COL != 4'b1011) cyc = i;
    end
    chk("bnc_next_col", 32'(COL), 32'h00000007);
    chk("bnc_novalid", 32'(vcnt - base), 32'd0);
    chk("bnc_noheld", 32'(key_held), 32'd0);

    // Reset while key 5 is held, then re-detection.
    kr = 2'd1; kc = 2'd1; pressed = 1'b1;
    wait_valid(100, seen);
    chk("k5_seen", 32'(seen), 32'd1);
    repeat (10) @(negedge clk);
    chk("k5_held", 32'(key_held), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_col", 32'(COL), 32'h0000000E);
    chk("mid_rst_code", 32'(key_code), 32'd0);
    chk("mid_rst_held", 32'(key_held), 32'd0);
    chk("mid_rst_valid", 32'(key_valid), 32'd0);
    chk("mid_rst_d0", 32'(digit0), 32'd0);
    chk("mid_rst_d1", 32'(digit1), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    base = vcnt;
    wait_valid(100, seen);
    chk("k5_reseen", 32'(seen), 32'd1);
    chk("k5_code", 32'(key_code), 32'h5);
    chk("k5_d0", 32'(digit0), 32'd5);
    chk("k5_d1", 32'(digit1), 32'd0);
    repeat (40) @(negedge clk);
    chk("k5_single", 32'(vcnt - base), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
